// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package seq_mult_pkg;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Magnitude of a two's-complement value; callers zero-extend and keep the low WIDTH bits.
  function automatic logic [MAX_WIDTH-1:0] twos_mag(input logic [MAX_WIDTH-1:0] v,
                                                    input logic                 is_neg);
    return is_neg ? (~v + MAX_WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/mult_datapath.sv
// Operand, accumulator and product registers with the single WIDTH+1 bit adder.
module mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic                 finish,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [MAX_WIDTH-1:0] a_mag_full, b_mag_full;
  logic                 unused_mag_bits;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   mag;

  assign a_mag_full      = twos_mag(MAX_WIDTH'(a), signed_mode & a[WIDTH-1]);
  assign b_mag_full      = twos_mag(MAX_WIDTH'(b), signed_mode & b[WIDTH-1]);
  assign unused_mag_bits = ^{a_mag_full, b_mag_full};

  always_comb begin
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    product_d = product_q;
    sum       = acc_q + (mplr_q[0] ? {1'b0, mcand_q} : '0);
    mag       = {acc_q[WIDTH-1:0], mplr_q};

    if (load) begin
      mcand_d = a_mag_full[WIDTH-1:0];
      mplr_d  = b_mag_full[WIDTH-1:0];
      acc_d   = '0;
      neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      // {acc, mplr} shifts right as one register; the sum's LSB becomes a product bit.
      acc_d  = {1'b0, sum[WIDTH:1]};
      mplr_d = {sum[0], mplr_q[WIDTH-1:1]};
    end

    if (finish) begin
      product_d = neg_q ? (~mag + (2*WIDTH)'(1)) : mag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: rtl/seq_mult_unit.sv
// Sequential multiplier top: control FSM, step counter and start/busy/done handshake.
module seq_mult_unit
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("seq_mult_unit: WIDTH outside legal range");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            done_q, done_d;
  logic            load, step, finish;

  // done is registered so it rises on the same edge that writes product.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        step    = 1'b1;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        finish  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .step       (step),
    .finish     (finish),
    .signed_mode(signed_mode),
    .a          (a),
    .b          (b),
    .product    (product)
  );

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Bench for seq_mult_unit: WIDTH=8 and WIDTH=4 instances checked against an arithmetic model.
module tb_seq_mult_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned w_of [2] = '{8, 4};

  logic       start_i [2];
  logic       sm_i    [2];
  logic [7:0] a_i     [2];
  logic [7:0] b_i     [2];

  logic        busy8, done8, busy4, done4;
  logic [15:0] prod8;
  logic [7:0]  prod4;

  seq_mult_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .signed_mode(sm_i[0]),
    .a(a_i[0]), .b(b_i[0]), .busy(busy8), .done(done8), .product(prod8)
  );

  seq_mult_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .signed_mode(sm_i[1]),
    .a(a_i[1][3:0]), .b(b_i[1][3:0]), .busy(busy4), .done(done4), .product(prod4)
  );

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_prod(int w, logic [7:0] a, logic [7:0] b, bit sm);
    longint sa, sb, p, lim;
    lim = longint'(1) << w;
    sa  = longint'(a) & (lim - 1);
    sb  = longint'(b) & (lim - 1);
    if (sm) begin
      if (sa >= (lim >> 1)) sa = sa - lim;
      if (sb >= (lim >> 1)) sb = sb - lim;
    end
    p = sa * sb;
    return 16'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  bit          m_busy [2];
  bit          m_done [2];
  logic [15:0] m_prod [2];
  logic [15:0] m_pend [2];
  longint      m_due  [2];
  longint      edge_n;
  bit          chk_en = 1'b0;

  // Timing rules: accept at edge k when idle, result and done at edge k+W+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_n = 0;
      for (int d = 0; d < 2; d++) begin
        m_busy[d] = 1'b0;
        m_done[d] = 1'b0;
        m_prod[d] = '0;
        m_pend[d] = '0;
        m_due[d]  = 0;
      end
    end else begin
      edge_n = edge_n + 1;
      for (int d = 0; d < 2; d++) begin
        m_done[d] = 1'b0;
        if (m_busy[d] && edge_n == m_due[d]) begin
          m_busy[d] = 1'b0;
          m_done[d] = 1'b1;
          m_prod[d] = m_pend[d];
        end else if (!m_busy[d] && start_i[d]) begin
          m_busy[d] = 1'b1;
          m_due[d]  = edge_n + longint'(w_of[d]) + 1;
          m_pend[d] = ref_prod(int'(w_of[d]), a_i[d], b_i[d], sm_i[d]);
        end
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic get_done(int d);
    return (d == 0) ? done8 : done4;
  endfunction

  function automatic logic [15:0] get_prod(int d);
    return (d == 0) ? prod8 : {8'h00, prod4};
  endfunction

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("busy8", 64'(busy8), 64'(m_busy[0]));
      check("done8", 64'(done8), 64'(m_done[0]));
      check("prod8", 64'(prod8), 64'(m_prod[0]));
      check("busy4", 64'(busy4), 64'(m_busy[1]));
      check("done4", 64'(done4), 64'(m_done[1]));
      check("prod4", 64'({8'h00, prod4}), 64'(m_prod[1]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int d, output int lat);
    lat = 0;
    while (!get_done(d) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b, input bit sm,
                        input logic [15:0] exp, input string name);
    int lat;
    @(negedge clk);
    a_i[d] = a; b_i[d] = b; sm_i[d] = sm; start_i[d] = 1'b1;
    @(negedge clk);
    start_i[d] = 1'b0;
    wait_done(d, lat);
    check({name, "_lat"}, 64'(lat), 64'(w_of[d] + 1));
    check({name, "_prod"}, 64'(get_prod(d)), 64'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, gap, nd;
    for (int d = 0; d < 2; d++) begin
      start_i[d] = 1'b0; sm_i[d] = 1'b0; a_i[d] = '0; b_i[d] = '0;
    end

    // Reset state
    @(negedge clk);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_prod8", 64'(prod8), 64'd0);
    check("rst_busy4", 64'(busy4), 64'd0);
    check("rst_prod4", 64'(prod4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Directed literals, WIDTH=8
    run_op(0, 8'd255, 8'd255, 1'b0, 16'hFE01, "u255x255");
    run_op(0, 8'd13,  8'd11,  1'b0, 16'd143,  "u13x11");
    run_op(0, 8'h80,  8'h80,  1'b1, 16'h4000, "s_min_sq");
    run_op(0, 8'hF9,  8'd5,   1'b1, 16'hFFDD, "s_m7x5");
    run_op(0, 8'd127, 8'hFF,  1'b1, 16'hFF81, "s_127xm1");
    run_op(0, 8'd0,   8'd200, 1'b0, 16'h0000, "zero_a");
    @(negedge clk);
    check("zero_busy_clear", 64'(busy8), 64'd0);
    run_op(0, 8'd200, 8'd200, 1'b0, 16'h9C40, "u200x200");

    // Reset in the middle of a run
    @(negedge clk);
    a_i[0] = 8'd200; b_i[0] = 8'd3; sm_i[0] = 1'b0; start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy8), 64'd0);
    check("midrst_done", 64'(done8), 64'd0);
    check("midrst_prod", 64'(prod8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) nd++;
    end
    check("midrst_no_done", 64'(nd), 64'd0);

    // Start pulsed during busy is ignored
    @(negedge clk);
    a_i[0] = 8'd13; b_i[0] = 8'd11; sm_i[0] = 1'b0; start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    repeat (2) @(negedge clk);
    a_i[0] = 8'd99; b_i[0] = 8'd77; start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    wait_done(0, lat);
    check("ign_prod", 64'(prod8), 64'd143);
    @(negedge clk);
    check("ign_not_queued", 64'(busy8), 64'd0);
    check("hold_prod", 64'(prod8), 64'd143);

    // Start held high: back-to-back throughput
    @(negedge clk);
    a_i[0] = 8'd2; b_i[0] = 8'd3; sm_i[0] = 1'b0; start_i[0] = 1'b1;
    @(negedge clk);
    a_i[0] = 8'd5; b_i[0] = 8'd7;
    wait_done(0, lat);
    check("b2b_first_prod", 64'(prod8), 64'd6);
    gap = 0;
    @(negedge clk);
    gap++;
    while (!done8 && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    start_i[0] = 1'b0;
    check("b2b_gap", 64'(gap), 64'd10);
    check("b2b_second_prod", 64'(prod8), 64'd35);

    // Exhaustive WIDTH=4, unsigned then signed
    for (int sm = 0; sm < 2; sm++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          run_op(1, 8'(ai), 8'(bi), sm[0], ref_prod(4, 8'(ai), 8'(bi), sm[0]), "w4");
        end
      end
    end

    // Random traffic on both instances, including starts while busy
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        start_i[d] = ($urandom_range(0, 2) == 0);
        a_i[d]     = 8'($urandom);
        b_i[d]     = 8'($urandom);
        sm_i[d]    = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    start_i[0] = 1'b0;
    start_i[1] = 1'b0;
    repeat (20) @(negedge clk);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_mult_unit.md
Name: seq_mult_unit

Overview:
- Iterative shift-add multiplier, parametrised successor to the team's 4x4 combinational array multiplier.
- Multiplies two WIDTH-bit operands in either unsigned or two's-complement signed mode and returns a 2*WIDTH-bit product.
- Uses a start/busy/done handshake so it can sit behind the lab calculator FSM and drive the 7-segment display path.
- Trades latency (WIDTH+1 cycles) for area: one adder of WIDTH+1 bits instead of WIDTH-1 ripple adders.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- signed_mode  input  1  1 = two's-complement operands and product; 0 = unsigned. Captured with the operands.
- a  input  WIDTH  multiplicand; captured on the accepted start.
- b  input  WIDTH  multiplier; captured on the accepted start.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse; product is valid and updated in this cycle.
- product  output  2*WIDTH  result register; holds its value until the next completion.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, product=0, count=0, internal registers=0. Reset mid-operation aborts the operation with no done pulse.
- States:
  - IDLE: busy=0. On start=1, capture a, b and signed_mode, then go to RUN with count=0.
  - RUN: busy=1, stays for exactly WIDTH cycles.
  - FIN: busy=1, one cycle, then returns to IDLE.
- Signed handling (applied at capture):
  - Magnitudes |a| and |b| are formed in WIDTH bits, treated as unsigned.
  - -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits unsigned in WIDTH bits.
  - neg = a[MSB] ^ b[MSB] when signed_mode=1, else neg=0.
  - With signed_mode=0, operands pass through unchanged.
- RUN step, per cycle:
  - If mplr[0]=1, acc_hi (WIDTH+1 bits) = acc_hi + mcand.
  - Shift {acc_hi, mplr} right by one; mplr shifts out as product bits shift in.
  - count increments; leave RUN when count reaches WIDTH-1.
- FIN: mag = {acc_hi[WIDTH-1:0], mplr}.
  - product <= neg ? -mag : mag (2*WIDTH-bit two's complement).
  - done=1 for this single cycle; next state is IDLE.
  - busy falls on the edge leaving FIN.
- Latency: start accepted at edge k -> busy=1 from edge k -> done=1 and product updated from edge k+WIDTH+1 (one cycle) -> busy=0 after edge k+WIDTH+1.
- Back-to-back: start held high is accepted in the IDLE cycle right after done; throughput is one result per WIDTH+2 cycles.
- start while busy=1 is ignored, not queued. Operand changes during busy have no effect.
- Zero operand: normal latency, product=0, done pulses as usual; no early exit.
- Signed extremes:
  - (-2^(W-1)) * (-2^(W-1)) = +2^(2W-2), which fits in 2*WIDTH bits.
  - Overflow is impossible in both modes.
- product is never X after reset. done and busy are never high outside the FIN/RUN windows described above.

Decomposition:
- Package seq_mult_pkg:
  - state enum {IDLE, RUN, FIN}, 2 bits.
  - function for two's-complement magnitude.
  - constant for minimum legal WIDTH.
- Sub-module mult_datapath: operand/accumulator registers, adder and shifter, controlled by load/step/finish strobes.
- seq_mult_unit keeps the FSM, counter and handshake outputs.

Test Plan:
- Reset: assert rst_n=0 mid-RUN (WIDTH=8, a=200, b=3) -> busy=0, done=0 and product=0 immediately; no done pulse afterwards.
- Unsigned, WIDTH=8: a=255, b=255, signed_mode=0 -> after exactly 9 cycles, done=1 for one cycle with product=16'hFE01. Also a=13, b=11 -> 143.
- Signed, WIDTH=8:
  - a=-128, b=-128 -> 16'h4000.
  - a=-7, b=5 -> 16'hFFDD (-35).
  - a=127, b=-1 -> 16'hFF81.
- Handshake: start pulsed again at cycle 3 of a run -> ignored; first result is unchanged. Start held high -> second op accepted in the cycle after done. Product holds its value between completions.
- WIDTH=4 instance (matches the 4x4 lab use): exhaustive 256 unsigned and 256 signed pairs checked against a reference model -> all match, latency 5 cycles each.
- Zero operand, WIDTH=8: a=0, b=200 -> done after 9 cycles, product=0, busy cleared.
